// File: rtl/fetch_seq.sv
// fetch_seq: instruction sequencer stepping each instruction through
// FETCH/DECODE/EXEC/WB over a req/ack memory port.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   mem_addr, mem_req        fetch address (= pc) and request
//   mem_ack, mem_rdata       memory ack with same-cycle instruction byte
//   instr                    instruction register feeding decode
//   exec_en                  high in every EXEC cycle
//   exec_done, wb_req        execute finished / instruction needs writeback
//   jmp_en, jmp_addr         take jump at exec_done, jump target
//   we                       one-cycle register-file write strobe in WB
//   step                     single-step pulse (SEQ_SINGLE_STEP_EN only)
//   halt_req, halted         stop at next instruction boundary / in HALT
//   fault                    sticky fetch-timeout flag
//
// Optional feature macro: SEQ_SINGLE_STEP_EN adds the step input, which runs
// one instruction out of HALT while halt_req stays high.
module fetch_seq #(
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter int                FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr,
    output logic              exec_en,
    input  logic              exec_done,
    input  logic              wb_req,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              we,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              halt_req,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t            state, nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [7:0]        instr_nxt;
    logic              step_go;
    logic              stepping;
    logic              to_halt;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    // Rising edge only, so a held step runs a single instruction.
    assign step_go = step & ~step_q & halt_req & (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q   <= 1'b0;
            stepping <= 1'b0;
        end else begin
            step_q <= step;
            // Set when leaving HALT on a step, cleared on return to HALT.
            if (state == S_HALT)
                stepping <= step_go;
        end
    end
`else
    assign step_go  = 1'b0;
    assign stepping = 1'b0;
`endif

    // A stepped instruction always returns to HALT at its boundary.
    assign to_halt = halt_req | stepping;

    always_comb begin
        nxt       = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        instr_nxt = instr;
        unique case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    instr_nxt = mem_rdata;
                    cnt_nxt   = 8'd0;
                    nxt       = S_DECODE;
                end else if (cnt == CNT_LAST) begin
                    nxt = S_FAULT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_DECODE: begin
                pc_nxt = pc + ADDR_W'(1);
                nxt    = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (jmp_en)
                        pc_nxt = jmp_addr;
                    if (wb_req)
                        nxt = S_WB;
                    else
                        nxt = to_halt ? S_HALT : S_FETCH;
                end
            end
            S_WB: nxt = to_halt ? S_HALT : S_FETCH;
            S_HALT: begin
                if (step_go || !halt_req)
                    nxt = S_FETCH;
            end
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they stay pure Moore
    // and still drop the moment rst asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            cnt     <= 8'd0;
            instr   <= 8'h00;
            mem_req <= 1'b0;
            exec_en <= 1'b0;
            we      <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= nxt;
            pc      <= pc_nxt;
            cnt     <= cnt_nxt;
            instr   <= instr_nxt;
            mem_req <= (nxt == S_FETCH);
            exec_en <= (nxt == S_EXEC);
            we      <= (nxt == S_WB);
            halted  <= (nxt == S_HALT);
            fault   <= (nxt == S_FAULT);
        end
    end

    assign mem_addr = pc;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed bench for fetch_seq.
// Drives and samples on the falling edge; design state moves on the rising edge.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic        exec_en;
    logic        exec_done;
    logic        wb_req;
    logic        jmp_en;
    logic [15:0] jmp_addr;
    logic        we;
    logic        step;
    logic        halt_req;
    logic        halted;
    logic        fault;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fetch_seq dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .instr     (instr),
        .exec_en   (exec_en),
        .exec_done (exec_done),
        .wb_req    (wb_req),
        .jmp_en    (jmp_en),
        .jmp_addr  (jmp_addr),
        .we        (we),
`ifdef SEQ_SINGLE_STEP_EN
        .step      (step),
`endif
        .halt_req  (halt_req),
        .halted    (halted),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
        exec_done = 1'b1;
        wb_req    = 1'b0;
        jmp_en    = 1'b0;
        jmp_addr  = 16'h0000;
        step      = 1'b0;
        halt_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        check("rst_req", mem_req, 0);
        check("rst_we", we, 0);
        check("rst_exec", exec_en, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_instr", instr, 8'h00);
        check("rst_addr", mem_addr, 16'h0000);

        // test 1: 3-cycle instructions, pc 0->1->2
        rst = 1'b1;
        check("idle_req", mem_req, 0);
        tick();
        check("f0_req", mem_req, 1);
        check("f0_addr", mem_addr, 16'h0000);
        tick();
        check("d0_instr", instr, 8'hA5);
        check("d0_req", mem_req, 0);
        check("d0_exec", exec_en, 0);
        tick();
        check("e0_exec", exec_en, 1);
        check("e0_pc", mem_addr, 16'h0001);
        tick();
        check("f1_req", mem_req, 1);
        check("f1_addr", mem_addr, 16'h0001);
        tick();
        tick();
        check("e1_pc", mem_addr, 16'h0002);

        // test 2: writeback strobe
        wb_req = 1'b1;
        tick();
        check("wb_we", we, 1);
        check("wb_exec", exec_en, 0);
        check("wb_req_lo", mem_req, 0);
        tick();
        check("wb_we_off", we, 0);
        check("f2_req", mem_req, 1);
        check("f2_addr", mem_addr, 16'h0002);
        wb_req    = 1'b0;
        mem_rdata = 8'h3C;
        tick();
        check("d2_instr", instr, 8'h3C);
        tick();
        check("e2_exec", exec_en, 1);
        tick();
        check("nowb_we", we, 0);
        check("f3_req", mem_req, 1);
        check("f3_addr", mem_addr, 16'h0003);

        // test 3: jump, then pc wrap
        tick();
        tick();
        jmp_en   = 1'b1;
        jmp_addr = 16'h1234;
        tick();
        check("jmp_addr", mem_addr, 16'h1234);
        check("jmp_req", mem_req, 1);
        jmp_en = 1'b0;
        tick();
        tick();
        check("jmp_inc", mem_addr, 16'h1235);
        jmp_en   = 1'b1;
        jmp_addr = 16'hFFFF;
        tick();
        check("ffff_addr", mem_addr, 16'hFFFF);
        jmp_en = 1'b0;
        tick();
        tick();
        check("wrap_pc", mem_addr, 16'h0000);
        tick();
        check("wrap_fetch", mem_req, 1);
        check("wrap_addr", mem_addr, 16'h0000);

        // test 5: halt raised mid-EXEC, done after 3 EXEC cycles
        exec_done = 1'b0;
        tick();
        tick();
        check("h_exec1", exec_en, 1);
        halt_req = 1'b1;
        tick();
        check("h_exec2", exec_en, 1);
        check("h_nohalt", halted, 0);
        tick();
        check("h_exec3", exec_en, 1);
        exec_done = 1'b1;
        tick();
        check("h_halted", halted, 1);
        check("h_exec_off", exec_en, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("h_noreq", mem_req, 0);
        end
        check("h_pc", mem_addr, 16'h0001);

`ifdef SEQ_SINGLE_STEP_EN
        // test 6: one stepped instruction, then back to HALT
        step = 1'b1;
        tick();
        check("s_req", mem_req, 1);
        check("s_addr", mem_addr, 16'h0001);
        check("s_nohalt", halted, 0);
        step = 1'b0;
        tick();
        tick();
        check("s_exec", exec_en, 1);
        tick();
        check("s_halted", halted, 1);
        check("s_pc", mem_addr, 16'h0002);
        tick();
        check("s_noreq", mem_req, 0);
        halt_req = 1'b0;
        tick();
        check("r_req", mem_req, 1);
        check("r_addr", mem_addr, 16'h0002);
`else
        halt_req = 1'b0;
        tick();
        check("r_req", mem_req, 1);
        check("r_addr", mem_addr, 16'h0001);
`endif

        // test 4: fetch timeout after 15 FETCH cycles
        mem_ack = 1'b0;
        for (int i = 0; i < 14; i++)
            tick();
        check("t_req15", mem_req, 1);
        check("t_nofault", fault, 0);
        tick();
        check("t_fault", fault, 1);
        check("t_req_lo", mem_req, 0);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        check("t_sticky", fault, 1);
        check("t_exec", exec_en, 0);
        check("t_req_held", mem_req, 0);
        rst = 1'b0;
        #1;
        check("t_clear", fault, 0);

        // reset mid-FETCH drops mem_req without a clock edge
        @(negedge clk);
        rst     = 1'b1;
        mem_ack = 1'b0;
        tick();
        tick();
        check("m_req", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("m_req_drop", mem_req, 0);
        check("m_addr", mem_addr, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
